// File: rtl/tt_response_checker_pkg.sv
// Shared types and sizing constants for the truth-table response checker.
package tt_response_checker_pkg;

   localparam int unsigned N_VEC = 16;  // vectors per sweep
   localparam int unsigned IDX_W = 4;   // vector index width
   localparam int unsigned CNT_W = 5;   // error counter width, holds 0..16
   localparam int unsigned TMR_W = 4;   // settle timer width, holds 1..15

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/tt_response_checker_if.sv
// Sweep control/result bundle plus the stimulus/response pins of the DUT under test.
interface tt_response_checker_if;
   import tt_response_checker_pkg::*;

   logic             start;
   logic             s;
   logic             a;
   logic             b;
   logic             c;
   logic             d;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_count;
   logic [N_VEC-1:0] err_mask;
   logic [IDX_W-1:0] cur_vec;

   // Bench / board side: requests sweeps and supplies the DUT response.
   modport master (
      output start, s,
      input  a, b, c, d, busy, done, pass, err_count, err_mask, cur_vec
   );

   // Checker side.
   modport slave (
      input  start, s,
      output a, b, c, d, busy, done, pass, err_count, err_mask, cur_vec
   );

endinterface

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; expire flags the last settle cycle of a vector.
module tt_settle_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expire
);

   logic [W-1:0] count_q;

   // Load takes priority; otherwise count down and rest at zero.
   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else if (load)
         count_q <= value;
      else if (count_q != '0)
         count_q <= count_q - 1'b1;
   end

   assign expire = (count_q == W'(1));

endmodule

// File: rtl/tt_response_checker.sv
// Sweeps all input vectors into a combinational DUT, compares its response with
// a golden truth table and records per-vector mismatches.
module tt_response_checker
   import tt_response_checker_pkg::*;
#(
   parameter int unsigned      N_IN          = 4,
   parameter logic [N_VEC-1:0] EXPECTED      = 16'h0000,
   parameter int unsigned      SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   tt_response_checker_if.slave  bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << N_IN) - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [N_VEC-1:0] err_mask_q, err_mask_d;
   logic             tmr_load;
   logic             tmr_expire;
   logic             mismatch;

   tt_settle_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .value  (TMR_W'(SETTLE_CYCLES)),
      .expire (tmr_expire)
   );

   // Case inequality so an X/Z response counts as a mismatch.
   assign mismatch = (bus.s !== EXPECTED[idx_q]);

   // State, vector index and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         err_count_q <= '0;
         err_mask_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         err_count_q <= err_count_d;
         err_mask_q  <= err_mask_d;
      end
   end

   // Next-state, vector advance and mismatch accumulation.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      err_count_d = err_count_q;
      err_mask_d  = err_mask_q;
      tmr_load    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               err_count_d = '0;
               err_mask_d  = '0;
               idx_d       = '0;
               tmr_load    = 1'b1;
               state_d     = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (tmr_expire)
               state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (mismatch) begin
               err_mask_d[idx_q] = 1'b1;
               err_count_d       = err_count_q + 1'b1;
            end
            // Index returns to zero on completion so the pins idle low in DONE.
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d    = idx_q + 1'b1;
               tmr_load = 1'b1;
               state_d  = ST_SETTLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign {bus.a, bus.b, bus.c, bus.d} = idx_q;
   assign bus.cur_vec   = idx_q;
   assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.pass      = (state_q == ST_DONE) && (err_count_q == '0);
   assign bus.err_count = err_count_q;
   assign bus.err_mask  = err_mask_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker driving a small behavioural DUT model.
module tb_tt_response_checker;
   import tt_response_checker_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   mode;
   int   tests = 0;
   int   fails = 0;
   logic golden;
   logic golden2;

   always #5 clk = ~clk;

   tt_response_checker_if bus  ();
   tt_response_checker_if bus2 ();

   tt_response_checker #(
      .N_IN          (4),
      .EXPECTED      (16'hF888),
      .SETTLE_CYCLES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   tt_response_checker #(
      .N_IN          (4),
      .EXPECTED      (16'hF888),
      .SETTLE_CYCLES (1)
   ) dut_fast (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   assign golden  = (bus.a & bus.b) | (bus.c & bus.d);
   assign golden2 = (bus2.a & bus2.b) | (bus2.c & bus2.d);
   assign bus2.s  = golden2;

   // Modelled DUT: 0 golden, 1 stuck-at-0, 2 inverted, 3 wrong only at vector 9
   // (a two-state simulator cannot carry X, so a wrong level stands in for it).
   always_comb begin
      case (mode)
         0:       bus.s = golden;
         1:       bus.s = 1'b0;
         2:       bus.s = ~golden;
         default: bus.s = (bus.cur_vec == 4'd9) ? ~golden : golden;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_busy"},  32'(bus.busy), 32'd0);
      check({tag, "_done"},  32'(bus.done), 32'd0);
      check({tag, "_pass"},  32'(bus.pass), 32'd0);
      check({tag, "_cnt"},   32'(bus.err_count), 32'd0);
      check({tag, "_mask"},  32'(bus.err_mask), 32'd0);
      check({tag, "_vec"},   32'(bus.cur_vec), 32'd0);
      check({tag, "_abcd"},  32'({bus.a, bus.b, bus.c, bus.d}), 32'd0);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Runs until done (bounded); flags any cycle where the driven vector is not n/3.
   task automatic wait_done(input int n0, output int n, output bit bad);
      n   = n0;
      bad = 1'b0;
      while (!bus.done && n < 200) begin
         if (bus.cur_vec != 4'(n / 3) || {bus.a, bus.b, bus.c, bus.d} != 4'(n / 3))
            bad = 1'b1;
         tick();
         n++;
      end
   endtask

   task automatic sweep_results(input string tag, input int n, input bit bad,
                                input logic [4:0] cnt, input logic [15:0] mask,
                                input logic ps);
      check({tag, "_latency"}, 32'(n), 32'd48);
      check({tag, "_hold"},    32'(bad), 32'd0);
      check({tag, "_cnt"},     32'(bus.err_count), 32'(cnt));
      check({tag, "_mask"},    32'(bus.err_mask), 32'(mask));
      check({tag, "_pass"},    32'(bus.pass), 32'(ps));
      check({tag, "_busy"},    32'(bus.busy), 32'd0);
      check({tag, "_abcd"},    32'({bus.a, bus.b, bus.c, bus.d}), 32'd0);
   endtask

   initial begin
      int n;
      bit bad;

      rst        = 1'b1;
      mode       = 0;
      bus.start  = 1'b0;
      bus2.start = 1'b0;
      tick();
      tick();
      check_reset("reset");
      rst = 1'b0;
      tick();

      // Golden DUT
      pulse_start();
      check("accept_busy", 32'(bus.busy), 32'd1);
      check("accept_done", 32'(bus.done), 32'd0);
      check("accept_vec",  32'(bus.cur_vec), 32'd0);
      wait_done(0, n, bad);
      sweep_results("golden", n, bad, 5'd0, 16'h0000, 1'b1);

      // Stuck-at-0, started from DONE
      mode = 1;
      pulse_start();
      check("restart_done", 32'(bus.done), 32'd0);
      check("restart_vec",  32'(bus.cur_vec), 32'd0);
      check("restart_busy", 32'(bus.busy), 32'd1);
      wait_done(0, n, bad);
      sweep_results("stuck0", n, bad, 5'd7, 16'hF888, 1'b0);

      // Inverted DUT
      mode = 2;
      pulse_start();
      wait_done(0, n, bad);
      sweep_results("invert", n, bad, 5'd16, 16'hFFFF, 1'b0);

      // Single bad vector
      mode = 3;
      pulse_start();
      wait_done(0, n, bad);
      sweep_results("vec9", n, bad, 5'd1, 16'h0200, 1'b0);

      // start while busy is ignored
      mode = 0;
      pulse_start();
      repeat (10) @(posedge clk);
      #1;
      pulse_start();
      wait_done(11, n, bad);
      sweep_results("busy_start", n, bad, 5'd0, 16'h0000, 1'b1);

      // rst mid-sweep at vector 5
      pulse_start();
      n = 0;
      while (bus.cur_vec != 4'd5 && n < 100) begin
         tick();
         n++;
      end
      check("reach_vec5", 32'(bus.cur_vec), 32'd5);
      rst = 1'b1;
      tick();
      check_reset("abort");
      rst = 1'b0;
      pulse_start();
      wait_done(0, n, bad);
      sweep_results("after_abort", n, bad, 5'd0, 16'h0000, 1'b1);

      // rst wins over start in the same cycle
      rst       = 1'b1;
      bus.start = 1'b1;
      tick();
      rst       = 1'b0;
      bus.start = 1'b0;
      check_reset("rst_vs_start");
      tick();
      check("rst_vs_start_idle", 32'(bus.busy), 32'd0);

      // Minimum settle: each vector held 2 cycles
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      n = 0;
      while (!bus2.done && n < 200) begin
         tick();
         n++;
      end
      check("fast_latency", 32'(n), 32'd32);
      check("fast_pass",    32'(bus2.pass), 32'd1);
      check("fast_mask",    32'(bus2.err_mask), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
